// File: rtl/memwb_if.sv
// Execute-side handshake and memory-bus signals of the memwb stage.
// The stage uses the slave modport; the execute/bus environment uses master.
interface memwb_if #(
  parameter int RW    = 16,
  parameter int REGNO = 8
);
  // Execute -> stage: an instruction transfers on any cycle with i_submit & o_ready.
  logic             i_submit;
  logic             o_ready;
  logic [RW-1:0]    i_data;
  logic [RW-1:0]    i_addr;
  logic [REGNO-1:0] i_reg_ie;
  logic             i_mem_access;
  logic             i_mem_we;
  logic             i_mem_width;
  logic [REGNO-1:0] o_reg_ie;
  logic [RW-1:0]    o_reg_data;
  logic             o_mem_exception;
  logic             o_mem_req;
  logic             o_mem_we;
  logic [RW-1:0]    o_mem_addr;
  logic [RW-1:0]    o_mem_data;
  logic [1:0]       o_mem_sel;
  logic             i_mem_ack;
  logic             i_mem_err;
  logic [RW-1:0]    i_mem_data;
  logic             dbg_busy;

  modport slave (
    input  i_submit, i_data, i_addr, i_reg_ie, i_mem_access, i_mem_we, i_mem_width,
    input  i_mem_ack, i_mem_err, i_mem_data,
    output o_ready, o_reg_ie, o_reg_data, o_mem_exception,
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_data, o_mem_sel, dbg_busy
  );

  modport master (
    output i_submit, i_data, i_addr, i_reg_ie, i_mem_access, i_mem_we, i_mem_width,
    output i_mem_ack, i_mem_err, i_mem_data,
    input  o_ready, o_reg_ie, o_reg_data, o_mem_exception,
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_data, o_mem_sel, dbg_busy
  );
endinterface

// File: rtl/memwb.sv
// Memory/writeback stage: zero-latency ALU writeback, single-outstanding load/store bus.
// Optional bus timeout enabled by defining MEM_TIMEOUT_EN.
module memwb #(
  parameter int RW      = 16,
  parameter int REGNO   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic   i_clk,
  input  logic   i_rst,
  memwb_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_e;

  state_e           state_q, state_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic             width_q, width_d;
  logic [1:0]       sel_q, sel_d;
  logic [RW-1:0]    addr_q, addr_d;
  logic [RW-1:0]    data_q, data_d;
  logic [REGNO-1:0] reg_ie_q, reg_ie_d;
  logic             busy, timeout, fail, okay;
  logic [RW-1:0]    load_data;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("memwb: TIMEOUT must fit the 8-bit wait counter");
  end

  assign busy = (state_q == BUSY);

`ifdef MEM_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  assign timeout = busy && (cnt_q == 8'(TIMEOUT));
`else
  assign timeout = 1'b0;
`endif

  // Error (bus or timeout) wins over ack when both land in the same cycle.
  assign fail = busy & (bus.i_mem_err | timeout);
  assign okay = busy & bus.i_mem_ack & ~fail;

  always_comb begin
    state_d   = state_q;
    mem_req_d = mem_req_q;
    mem_we_d  = mem_we_q;
    width_d   = width_q;
    sel_d     = sel_q;
    addr_d    = addr_q;
    data_d    = data_q;
    reg_ie_d  = reg_ie_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    if (!busy) begin
      if (bus.i_submit && bus.i_mem_access) begin
        state_d   = BUSY;
        mem_req_d = 1'b1;
        mem_we_d  = bus.i_mem_we;
        width_d   = bus.i_mem_width;
        addr_d    = bus.i_addr;
        reg_ie_d  = bus.i_reg_ie;
        sel_d     = bus.i_mem_width ? (bus.i_addr[0] ? 2'b10 : 2'b01) : 2'b11;
        // Byte stores put the byte on both lanes; o_mem_sel picks the live one.
        data_d    = bus.i_mem_width ? {(RW/8){bus.i_data[7:0]}} : bus.i_data;
`ifdef MEM_TIMEOUT_EN
        cnt_d     = 8'd0;
`endif
      end
    end else if (fail || okay) begin
      state_d   = IDLE;
      mem_req_d = 1'b0;
    end else begin
`ifdef MEM_TIMEOUT_EN
      cnt_d = cnt_q + 8'd1;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      width_q   <= 1'b0;
      sel_q     <= 2'b00;
      addr_q    <= '0;
      data_q    <= '0;
      reg_ie_q  <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q     <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
      width_q   <= width_d;
      sel_q     <= sel_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      reg_ie_q  <= reg_ie_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  always_comb begin
    load_data = bus.i_mem_data;
    if (width_q) begin
      load_data      = '0;
      load_data[7:0] = addr_q[0] ? bus.i_mem_data[15:8] : bus.i_mem_data[7:0];
    end
  end

  always_comb begin
    bus.o_reg_ie = '0;
    if (!i_rst) begin
      if (!busy && bus.i_submit && !bus.i_mem_access) bus.o_reg_ie = bus.i_reg_ie;
      else if (okay && !mem_we_q)                    bus.o_reg_ie = reg_ie_q;
    end
  end

  assign bus.o_reg_data      = busy ? load_data : bus.i_data;
  assign bus.o_mem_exception = fail & ~i_rst;
  assign bus.o_ready         = ~busy & ~i_rst;
  assign bus.o_mem_req       = mem_req_q;
  assign bus.o_mem_we        = mem_we_q;
  assign bus.o_mem_addr      = addr_q;
  assign bus.o_mem_data      = data_q;
  assign bus.o_mem_sel       = sel_q;
  assign bus.dbg_busy        = busy;
endmodule

// File: tb/tb_memwb.sv
// Bench for memwb: directed ALU/load/store/error/reset vectors; writebacks and
// exceptions are checked against an expected queue by a free-running monitor.
module tb_memwb;
  localparam int RW = 16, REGNO = 8, TIMEOUT = 255;

  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  memwb_if #(.RW(RW), .REGNO(REGNO)) bus ();
  memwb #(.RW(RW), .REGNO(REGNO), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  logic [24:0] exp_q[$];
  logic [24:0] mon_got, mon_exp;

  function automatic logic [24:0] pk(input logic exc, input logic [7:0] ie, input logic [15:0] d);
    return {exc, ie, d};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Monitor: every writeback or exception must match the head of the expected queue.
  always @(negedge i_clk) begin
    if (bus.o_reg_ie != '0 || bus.o_mem_exception) begin
      mon_got = {bus.o_mem_exception, bus.o_reg_ie, bus.o_reg_data};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL wb_stray act=%h exp=none", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_exp[24]) mon_got[15:0] = 16'h0;
        if (mon_got !== mon_exp) begin
          bad++;
          $display("FAIL wb act=%h exp=%h", mon_got, mon_exp);
        end
      end
    end
  end

  task automatic alu_op(input logic [7:0] ie, input logic [15:0] d);
    step();
    bus.i_submit = 1'b1; bus.i_mem_access = 1'b0; bus.i_reg_ie = ie; bus.i_data = d;
    if (ie != 8'h0) exp_q.push_back(pk(1'b0, ie, d));
    @(negedge i_clk);
    chk("alu_ready", 32'(bus.o_ready), 32'd1);
  endtask

  task automatic mem_op(input logic [15:0] addr, input logic [15:0] d, input logic [7:0] ie,
                        input logic we, input logic width, input int wait_n,
                        input logic [15:0] rdata, input logic err, input logic ack_too,
                        input logic poke, input logic [1:0] exp_sel,
                        input logic [15:0] exp_mdata, input logic [15:0] exp_rd);
    int lows;
    step();
    bus.i_submit = 1'b1; bus.i_mem_access = 1'b1; bus.i_addr = addr; bus.i_data = d;
    bus.i_reg_ie = ie; bus.i_mem_we = we; bus.i_mem_width = width;
    if (err) exp_q.push_back(pk(1'b1, 8'h0, 16'h0));
    else if (!we) exp_q.push_back(pk(1'b0, ie, exp_rd));
    @(negedge i_clk);
    chk("mem_submit_ready", 32'(bus.o_ready), 32'd1);
    step();
    bus.i_submit = 1'b0; bus.i_mem_access = 1'b0;
    if (poke) begin
      bus.i_submit = 1'b1; bus.i_reg_ie = 8'h80; bus.i_data = 16'hDEAD;
    end
    lows = 0;
    for (int i = 0; i < wait_n; i++) begin
      @(negedge i_clk);
      if (!bus.o_ready) lows++;
      chk("mem_req_wait", 32'(bus.o_mem_req), 32'd1);
      step();
      bus.i_submit = 1'b0;
    end
    bus.i_mem_data = rdata; bus.i_mem_err = err; bus.i_mem_ack = !err || ack_too;
    @(negedge i_clk);
    if (!bus.o_ready) lows++;
    chk("mem_req", 32'(bus.o_mem_req), 32'd1);
    chk("mem_sel", 32'(bus.o_mem_sel), 32'(exp_sel));
    chk("mem_addr", 32'(bus.o_mem_addr), 32'(addr));
    chk("mem_wdata", 32'(bus.o_mem_data), 32'(exp_mdata));
    chk("mem_we", 32'(bus.o_mem_we), 32'(we));
    step();
    bus.i_submit = 1'b0; bus.i_mem_ack = 1'b0; bus.i_mem_err = 1'b0;
    @(negedge i_clk);
    chk("mem_req_done", 32'(bus.o_mem_req), 32'd0);
    chk("mem_ready_done", 32'(bus.o_ready), 32'd1);
    chk("mem_ready_low_cycles", 32'(lows), 32'(wait_n + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_rst = 1'b1;
    bus.i_submit = 1'b1; bus.i_data = 16'h1111; bus.i_addr = 16'h0;
    bus.i_reg_ie = 8'h04; bus.i_mem_access = 1'b0; bus.i_mem_we = 1'b0;
    bus.i_mem_width = 1'b0; bus.i_mem_ack = 1'b0; bus.i_mem_err = 1'b0;
    bus.i_mem_data = 16'h0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_ready", 32'(bus.o_ready), 32'd0);
    chk("rst_reg_ie", 32'(bus.o_reg_ie), 32'd0);
    chk("rst_req", 32'(bus.o_mem_req), 32'd0);
    chk("rst_we", 32'(bus.o_mem_we), 32'd0);
    chk("rst_sel", 32'(bus.o_mem_sel), 32'd0);
    chk("rst_addr", 32'(bus.o_mem_addr), 32'd0);
    chk("rst_wdata", 32'(bus.o_mem_data), 32'd0);
    chk("rst_exc", 32'(bus.o_mem_exception), 32'd0);
    step();
    i_rst = 1'b0; bus.i_submit = 1'b0;

    alu_op(8'h04, 16'h1234);
    alu_op(8'h01, 16'hFFFF);
    alu_op(8'h00, 16'h5555);
    //     addr      data      ie     we    wd    wt rdata     err   ack2  poke  sel    wdata     rd
    mem_op(16'h0100, 16'h0000, 8'h02, 1'b0, 1'b0, 3, 16'hBEEF, 1'b0, 1'b0, 1'b0, 2'b11, 16'h0000, 16'hBEEF);
    mem_op(16'h0101, 16'h0000, 8'h08, 1'b0, 1'b1, 1, 16'hA55A, 1'b0, 1'b0, 1'b0, 2'b10, 16'h0000, 16'h00A5);
    mem_op(16'h0100, 16'h0000, 8'h08, 1'b0, 1'b1, 0, 16'hA55A, 1'b0, 1'b0, 1'b0, 2'b01, 16'h0000, 16'h005A);
    mem_op(16'h0003, 16'h00C3, 8'h10, 1'b1, 1'b1, 2, 16'h7777, 1'b0, 1'b0, 1'b1, 2'b10, 16'hC3C3, 16'h0000);
    mem_op(16'h0201, 16'h1357, 8'h00, 1'b1, 1'b0, 0, 16'h0000, 1'b0, 1'b0, 1'b0, 2'b11, 16'h1357, 16'h0000);
    mem_op(16'h0040, 16'h0000, 8'h20, 1'b0, 1'b0, 0, 16'h4444, 1'b1, 1'b0, 1'b0, 2'b11, 16'h0000, 16'h0000);
    mem_op(16'h0041, 16'h0000, 8'h20, 1'b0, 1'b1, 2, 16'hFFFF, 1'b1, 1'b1, 1'b0, 2'b10, 16'h0000, 16'h0000);
    alu_op(8'h40, 16'hABCD);

    // Reset while a load is outstanding; the ack that follows must be dropped.
    step();
    bus.i_submit = 1'b1; bus.i_mem_access = 1'b1; bus.i_addr = 16'h0300;
    bus.i_reg_ie = 8'h02; bus.i_mem_we = 1'b0; bus.i_mem_width = 1'b0;
    step();
    bus.i_submit = 1'b0; bus.i_mem_access = 1'b0;
    @(negedge i_clk);
    chk("rst_busy_req", 32'(bus.o_mem_req), 32'd1);
    step();
    i_rst = 1'b1;
    @(negedge i_clk);
    chk("rst_busy_ready", 32'(bus.o_ready), 32'd0);
    step();
    i_rst = 1'b0; bus.i_mem_ack = 1'b1; bus.i_mem_data = 16'h9999;
    @(negedge i_clk);
    chk("late_ack_req", 32'(bus.o_mem_req), 32'd0);
    chk("late_ack_ready", 32'(bus.o_ready), 32'd1);
    chk("late_ack_reg_ie", 32'(bus.o_reg_ie), 32'd0);
    step();
    bus.i_mem_ack = 1'b0;

`ifdef MEM_TIMEOUT_EN
    begin
      int busy_n;
      logic seen;
      step();
      bus.i_submit = 1'b1; bus.i_mem_access = 1'b1; bus.i_addr = 16'h0500;
      bus.i_reg_ie = 8'h01; bus.i_mem_we = 1'b0; bus.i_mem_width = 1'b0;
      exp_q.push_back(pk(1'b1, 8'h0, 16'h0));
      step();
      bus.i_submit = 1'b0; bus.i_mem_access = 1'b0;
      busy_n = 0;
      seen = 1'b0;
      for (int i = 0; i < TIMEOUT + 10 && !seen; i++) begin
        @(negedge i_clk);
        busy_n++;
        if (bus.o_mem_exception) seen = 1'b1;
        step();
      end
      chk("timeout_cycles", 32'(busy_n), 32'(TIMEOUT + 1));
    end
`endif

    step();
    alu_op(8'h80, 16'h0F0F);
    step();
    bus.i_submit = 1'b0;
    repeat (3) step();
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/memwb.md
# memwb

Memory/writeback stage directly downstream of the execute stage. It accepts one retired instruction per handshake. ALU results are forwarded to the register file in the same cycle. Loads and stores go to a single-outstanding memory bus, and load data is written back when the bus acknowledges. Bus errors and timeouts are reported back to execute as a memory exception, which execute turns into an interrupt.

## Interface
- RW, 16, data/address width in bits
- REGNO, 8, number of architectural registers (one-hot write-enable width)
- TIMEOUT, 255, max wait cycles for i_mem_ack before a timeout error (used only with MEM_TIMEOUT_EN)

- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_submit  in  1  execute presents a valid instruction
- o_ready  out  1  stage can accept; drives execute's i_next_ready
- i_data  in  RW  ALU result, or store data for memory ops
- i_addr  in  RW  byte address for memory ops
- i_reg_ie  in  REGNO  one-hot destination register (0 = none)
- i_mem_access, i_mem_we, i_mem_width  in  1 each  memory op / store / byte (1) vs word (0)
- o_reg_ie  out  REGNO  register-file write enable
- o_reg_data  out  RW  register-file write data
- o_mem_exception  out  1  one-cycle pulse: bus error or timeout
- o_mem_req  out  1  bus request
- o_mem_we  out  1  bus write
- o_mem_addr  out  RW  bus byte address
- o_mem_data  out  RW  bus write data
- o_mem_sel  out  2  byte lanes, [1] = high byte
- i_mem_ack  in  1  bus completion
- i_mem_err  in  1  bus error completion (takes priority over ack)
- i_mem_data  in  RW  bus read data, valid with i_mem_ack

## Operation
- States: IDLE and BUSY. o_ready = (state == IDLE) & ~i_rst.
- IDLE, i_submit & ~i_mem_access:
  - Combinational passthrough: o_reg_ie = i_reg_ie, o_reg_data = i_data.
  - State stays IDLE.
- IDLE, i_submit & i_mem_access:
  - Latch addr, data, we, width and reg_ie into holding registers.
  - Next state BUSY.
- BUSY:
  - o_mem_req = 1; bus outputs are driven from the holding registers and held stable until completion.
  - Lane select: word → o_mem_sel = 2'b11; byte → addr[0] ? 2'b10 : 2'b01.
  - Byte stores replicate data[7:0] onto both lanes.
  - Word accesses ignore addr[0]; there is no alignment fault.
- BUSY completion:
  - i_mem_err: o_mem_exception = 1 for that cycle, no writeback, next state IDLE.
  - i_mem_ack on a load: o_reg_ie = latched reg_ie. o_reg_data = i_mem_data for words, or the selected byte zero-extended for bytes. Next state IDLE.
  - i_mem_ack on a store: o_reg_ie = 0 (forced, even if the latched value is nonzero). Next state IDLE.
- Default outputs (no submit, or BUSY without completion): o_reg_ie = 0, o_mem_exception = 0.
- i_submit while BUSY is a protocol violation from execute and is ignored.

## Timing
- Reset values: state IDLE; o_mem_req 0; o_mem_we 0; o_mem_sel 0; o_mem_addr and o_mem_data 0; o_reg_ie 0 (forced during i_rst); o_mem_exception 0; o_ready 0 during i_rst.
- ALU ops: zero latency. Writeback occurs in the submit cycle, and o_ready stays 1.
- Memory ops:
  - o_mem_req rises the cycle after submit.
  - i_mem_ack or i_mem_err is accepted in any cycle in which o_mem_req = 1, including the first.
  - Writeback or exception occurs in the completion cycle.
  - o_mem_req and BUSY clear on the following edge; o_ready = 1 from the next cycle.
- Minimum memory op occupancy is 2 cycles (submit + 1 bus cycle).
- Ack and err in the same cycle are treated as err.
- Reset mid-transaction drops o_mem_req on the next edge. A late ack after reset is ignored.

## Configuration
- MEM_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to BUSY and increments each BUSY cycle without completion.
  - When the counter reaches TIMEOUT, the stage behaves exactly as on i_mem_err: exception pulse, no writeback, return to IDLE.
- MEM_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely.

## Test plan
- ALU op: i_submit, i_reg_ie = 8'h04, i_data = 16'h1234 → same cycle o_reg_ie = 8'h04, o_reg_data = 16'h1234, o_ready stays 1.
- Word load: addr 16'h0100, ack after 3 cycles with 16'hBEEF → o_mem_sel = 11, writeback 16'hBEEF in the ack cycle, o_ready low 4 cycles total.
- Byte load: addr 16'h0101, ack data 16'hA55A → o_mem_sel = 10, o_reg_data = 16'h00A5. Repeat at 16'h0100 → 16'h005A.
- Byte store: addr 16'h0003, data 16'h00C3 → o_mem_we = 1, o_mem_sel = 10, o_mem_data = 16'hC3C3, o_reg_ie = 0 at ack.
- Error: load with i_mem_err on the first BUSY cycle → o_mem_exception single pulse, o_reg_ie = 0, IDLE the next cycle. With MEM_TIMEOUT_EN and no ack → pulse after TIMEOUT BUSY cycles.
- Reset while BUSY, then ack arrives → o_mem_req 0 after the edge, no writeback, o_ready = 1 after reset deasserts.
